// File: rtl/snn_pkg.sv
// Shared constants and the loader state type for the SNN input-loader slice.
package snn_pkg;

    localparam int NUM_PIXELS = 784;
    localparam int BYTE_W     = 8;
    localparam int NUM_BYTES  = NUM_PIXELS / BYTE_W;
    localparam int ADDR_W     = 10;
    localparam int CNT_W      = 7;

    typedef enum logic [1:0] {
        LOAD      = 2'd0,
        FIRE      = 2'd1,
        WAIT_CORE = 2'd2
    } ldr_state_t;

endpackage

// File: rtl/snn_input_loader_if.sv
// Bundles the UART receive handshake and the SNN core read/control signals.
interface snn_input_loader_if;
    import snn_pkg::*;

    logic              rx_rdy;
    logic [BYTE_W-1:0] rx_data;
    logic              clr_rx_rdy;
    logic [ADDR_W-1:0] addr_input_unit;
    logic              q_input;
    logic              start;
    logic              done;
    logic              busy;
    logic              overrun;

    // The loader itself sits on the slave side.
    modport slave (
        input  rx_rdy, rx_data, addr_input_unit, done,
        output clr_rx_rdy, q_input, start, busy, overrun
    );

    // The environment (UART receiver plus SNN core) drives the master side.
    modport master (
        output rx_rdy, rx_data, addr_input_unit, done,
        input  clr_rx_rdy, q_input, start, busy, overrun
    );

endinterface

// File: rtl/snn_input_ram.sv
// 98x8 image store: byte-wide synchronous write, registered single-bit read.
module snn_input_ram
    import snn_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [CNT_W-1:0]  waddr_i,
    input  logic [BYTE_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic              q_o
);

    logic [BYTE_W-1:0] mem [NUM_BYTES];
    logic              q_q;
    logic              q_d;

    // Pixel select with out-of-range addresses forced to zero.
    always_comb begin
        q_d = 1'b0;
        if (raddr_i < ADDR_W'(NUM_PIXELS)) begin
            q_d = mem[raddr_i[ADDR_W-1:3]][raddr_i[2:0]];
        end
    end

    // Storage is not reset; a same-cycle read of the written word sees the old byte.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    // One-cycle read latency to line up with the core's synchronous memories.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/snn_input_loader.sv
// Collects a packed 28x28 binary frame from the UART, fires the core, then waits for done.
module snn_input_loader
    import snn_pkg::*;
(
    input logic               clk,
    input logic               rst,
    snn_input_loader_if.slave bus_io
);

    ldr_state_t        state_q, state_d;
    logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
    logic              clr_q, clr_d;
    logic              start_q, start_d;
    logic              busy_q, busy_d;
    logic              overrun_q, overrun_d;
    logic              accept;
    logic              we;

    // A held rx_rdy is only taken once: the acknowledge cycle blocks a second accept.
    assign accept = bus_io.rx_rdy && !clr_q;

    // Next-state and control decode.
    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        clr_d      = accept;
        start_d    = 1'b0;
        busy_d     = busy_q;
        overrun_d  = overrun_q;
        we         = 1'b0;
        case (state_q)
            LOAD: begin
                if (accept) begin
                    we = 1'b1;
                    if (byte_cnt_q == CNT_W'(NUM_BYTES - 1)) begin
                        byte_cnt_d = '0;
                        state_d    = FIRE;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 1'b1;
                    end
                end
            end
            FIRE: begin
                start_d = 1'b1;
                busy_d  = 1'b1;
                state_d = WAIT_CORE;
                if (accept) begin
                    overrun_d = 1'b1;
                end
            end
            WAIT_CORE: begin
                if (accept) begin
                    overrun_d = 1'b1;
                end
                if (bus_io.done) begin
                    busy_d  = 1'b0;
                    state_d = LOAD;
                end
            end
            default: begin
                state_d = LOAD;
            end
        endcase
    end

    // State and registered outputs; reset throws away any partial frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= LOAD;
            byte_cnt_q <= '0;
            clr_q      <= 1'b0;
            start_q    <= 1'b0;
            busy_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            clr_q      <= clr_d;
            start_q    <= start_d;
            busy_q     <= busy_d;
            overrun_q  <= overrun_d;
        end
    end

    snn_input_ram u_ram (
        .clk     (clk),
        .rst     (rst),
        .we_i    (we),
        .waddr_i (byte_cnt_q),
        .wdata_i (bus_io.rx_data),
        .raddr_i (bus_io.addr_input_unit),
        .q_o     (bus_io.q_input)
    );

    assign bus_io.clr_rx_rdy = clr_q;
    assign bus_io.start      = start_q;
    assign bus_io.busy       = busy_q;
    assign bus_io.overrun    = overrun_q;

endmodule

// File: tb/tb_snn_input_loader.sv
// Directed bench for snn_input_loader: frame load, start timing, reads, overrun, reset and done corners.
module tb_snn_input_loader;
    import snn_pkg::*;

    typedef struct {
        logic [9:0] addr;
        logic       expQ;
    } rdVec_t;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    int   startCount = 0;

    snn_input_loader_if bus();

    snn_input_loader dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    // Counts start cycles using the value present just before each rising edge.
    always @(posedge clk) begin
        if (bus.start === 1'b1) startCount++;
    end

    // Hard stop in case anything stalls.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, required finish before 1ms");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // One UART byte: raise rx_rdy for a cycle, report whether the ack came back.
    task automatic applyStimulus(input logic [7:0] d, output logic clrSeen);
        @(negedge clk);
        bus.rx_rdy  = 1'b1;
        bus.rx_data = d;
        @(negedge clk);
        clrSeen    = bus.clr_rx_rdy;
        bus.rx_rdy = 1'b0;
    endtask

    task automatic sendFrame(input logic [7:0] d, input int n);
        logic c;
        int   acks;
        acks = 0;
        for (int i = 0; i < n; i++) begin
            applyStimulus(d, c);
            if (c === 1'b1) acks++;
        end
        checkOutput("byte acks", 32'(acks), 32'(n));
    endtask

    task automatic readCheck(input string name, input logic [9:0] a, input logic e);
        @(negedge clk);
        bus.addr_input_unit = a;
        @(negedge clk);
        checkOutput(name, 32'(bus.q_input), 32'(e));
    endtask

    task automatic pulseDone();
        @(negedge clk);
        bus.done = 1'b1;
        @(negedge clk);
        bus.done = 1'b0;
    endtask

    initial begin
        rdVec_t frameA[8];
        rdVec_t frameB[8];
        logic   c;
        int     clrHigh;

        frameA[0] = '{10'd0,    1'b1};
        frameA[1] = '{10'd1,    1'b0};
        frameA[2] = '{10'd783,  1'b1};
        frameA[3] = '{10'd782,  1'b0};
        frameA[4] = '{10'd784,  1'b0};
        frameA[5] = '{10'd1023, 1'b0};
        frameA[6] = '{10'd7,    1'b0};
        frameA[7] = '{10'd8,    1'b0};

        frameB[0] = '{10'd0,    1'b0};
        frameB[1] = '{10'd1,    1'b1};
        frameB[2] = '{10'd2,    1'b0};
        frameB[3] = '{10'd3,    1'b1};
        frameB[4] = '{10'd783,  1'b1};
        frameB[5] = '{10'd782,  1'b0};
        frameB[6] = '{10'd784,  1'b0};
        frameB[7] = '{10'd1023, 1'b0};

        rst                 = 1'b1;
        bus.rx_rdy          = 1'b0;
        bus.rx_data         = 8'h00;
        bus.addr_input_unit = 10'd0;
        bus.done            = 1'b0;

        // Reset state.
        repeat (3) @(negedge clk);
        checkOutput("rst clr", 32'(bus.clr_rx_rdy), 32'd0);
        checkOutput("rst start", 32'(bus.start), 32'd0);
        checkOutput("rst busy", 32'(bus.busy), 32'd0);
        checkOutput("rst overrun", 32'(bus.overrun), 32'd0);
        checkOutput("rst q", 32'(bus.q_input), 32'd0);
        rst = 1'b0;

        // Held rx_rdy: one accept, one ack cycle.
        clrHigh = 0;
        @(negedge clk);
        bus.rx_rdy  = 1'b1;
        bus.rx_data = 8'h01;
        @(negedge clk);
        if (bus.clr_rx_rdy === 1'b1) clrHigh++;
        @(negedge clk);
        if (bus.clr_rx_rdy === 1'b1) clrHigh++;
        bus.rx_rdy = 1'b0;
        @(negedge clk);
        if (bus.clr_rx_rdy === 1'b1) clrHigh++;
        checkOutput("hold ack cycles", 32'(clrHigh), 32'd1);
        checkOutput("hold byte_cnt", 32'(dut.byte_cnt_q), 32'd1);

        // Rest of frame 1; the last byte is hand-timed to check the start pulse.
        sendFrame(8'h00, 96);
        checkOutput("no early start", 32'(startCount), 32'd0);
        @(negedge clk);
        bus.rx_rdy  = 1'b1;
        bus.rx_data = 8'h80;
        @(negedge clk);
        checkOutput("last ack", 32'(bus.clr_rx_rdy), 32'd1);
        checkOutput("start not yet", 32'(bus.start), 32'd0);
        bus.rx_rdy = 1'b0;
        @(negedge clk);
        checkOutput("start pulse", 32'(bus.start), 32'd1);
        checkOutput("busy at start", 32'(bus.busy), 32'd1);
        @(negedge clk);
        checkOutput("start ends", 32'(bus.start), 32'd0);
        checkOutput("start count f1", 32'(startCount), 32'd1);

        for (int i = 0; i < 8; i++) begin
            readCheck("frame1 read", frameA[i].addr, frameA[i].expQ);
        end

        // Byte while the core runs: acked, dropped, overrun sticks.
        applyStimulus(8'hFF, c);
        checkOutput("overrun ack", 32'(c), 32'd1);
        checkOutput("overrun flag", 32'(bus.overrun), 32'd1);
        checkOutput("busy kept", 32'(bus.busy), 32'd1);
        for (int a = 8; a < 16; a++) begin
            readCheck("buffer unchanged", 10'(a), 1'b0);
        end
        pulseDone();
        checkOutput("done busy", 32'(bus.busy), 32'd0);
        checkOutput("done state", 32'(dut.state_q), 32'(LOAD));
        checkOutput("done byte_cnt", 32'(dut.byte_cnt_q), 32'd0);

        // Second frame of all ones.
        sendFrame(8'hFF, 98);
        repeat (2) @(negedge clk);
        checkOutput("start count f2", 32'(startCount), 32'd2);
        readCheck("frame2 read", 10'd8, 1'b1);
        pulseDone();

        // Reset in the middle of a frame.
        sendFrame(8'h00, 50);
        checkOutput("mid byte_cnt", 32'(dut.byte_cnt_q), 32'd50);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("mid rst overrun", 32'(bus.overrun), 32'd0);
        checkOutput("mid rst byte_cnt", 32'(dut.byte_cnt_q), 32'd0);
        rst = 1'b0;
        sendFrame(8'hAA, 97);
        repeat (2) @(negedge clk);
        checkOutput("no start at 97", 32'(startCount), 32'd2);
        applyStimulus(8'hAA, c);
        repeat (2) @(negedge clk);
        checkOutput("start count f3", 32'(startCount), 32'd3);
        for (int i = 0; i < 8; i++) begin
            readCheck("frame3 read", frameB[i].addr, frameB[i].expQ);
        end
        checkOutput("f3 overrun", 32'(bus.overrun), 32'd0);

        // done while already loading is ignored.
        pulseDone();
        pulseDone();
        checkOutput("load done busy", 32'(bus.busy), 32'd0);
        checkOutput("load done state", 32'(dut.state_q), 32'(LOAD));
        checkOutput("load done cnt", 32'(dut.byte_cnt_q), 32'd0);
        checkOutput("load done start", 32'(startCount), 32'd3);

        // done and a byte in the same cycle while the core runs.
        sendFrame(8'h00, 98);
        repeat (2) @(negedge clk);
        checkOutput("start count f4", 32'(startCount), 32'd4);
        @(negedge clk);
        bus.rx_rdy  = 1'b1;
        bus.rx_data = 8'hFF;
        bus.done    = 1'b1;
        @(negedge clk);
        checkOutput("coinc ack", 32'(bus.clr_rx_rdy), 32'd1);
        bus.rx_rdy = 1'b0;
        bus.done   = 1'b0;
        checkOutput("coinc busy", 32'(bus.busy), 32'd0);
        checkOutput("coinc overrun", 32'(bus.overrun), 32'd1);
        checkOutput("coinc state", 32'(dut.state_q), 32'(LOAD));
        checkOutput("coinc byte_cnt", 32'(dut.byte_cnt_q), 32'd0);
        readCheck("coinc discarded", 10'd0, 1'b0);
        applyStimulus(8'h01, c);
        checkOutput("post coinc cnt", 32'(dut.byte_cnt_q), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
